// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - Instruction fetch stage: fetch PC, in-order imem requests, prefetch queue.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        fetch_valid,
  output logic [31:0] fetch_instr,
  output logic [31:0] fetch_pc_plus4
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   q_instr [QDEPTH];
  logic [31:0]   q_pc4   [QDEPTH];
  logic [AW-1:0] q_head, q_tail;
  logic [CW-1:0] q_count;

  // Addresses of accepted requests, in issue order, awaiting their response.
  logic [31:0]   a_mem [QDEPTH];
  logic [AW-1:0] a_head, a_tail;
  logic [CW-1:0] outstanding, discard;

  logic          accept, resp, push, pop;
  logic [31:0]   resp_addr;
  logic [CW:0]   credit;
  logic          unused_lsbs;

  assign unused_lsbs = ^redirect_pc[1:0];

  // Queued words plus in-flight requests never exceed QDEPTH, so a response always has a slot.
  assign credit    = {1'b0, q_count} + {1'b0, outstanding};
  assign imem_req  = reset && !redirect_valid && (credit < (CW+1)'(QDEPTH));
  assign imem_addr = fetch_pc;
  assign accept    = imem_req && imem_ready;
  assign resp      = imem_rvalid && (outstanding != '0);
  assign resp_addr = a_mem[a_head];
  assign push      = resp && (discard == '0) && !redirect_valid;
  assign pop       = fetch_valid && !stall && !redirect_valid;

  assign fetch_valid    = (q_count != '0);
  assign fetch_instr    = fetch_valid ? q_instr[q_head] : 32'h0;
  assign fetch_pc_plus4 = fetch_valid ? q_pc4[q_head]   : 32'h0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      q_head      <= '0;
      q_tail      <= '0;
      q_count     <= '0;
      a_head      <= '0;
      a_tail      <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      if (accept) a_tail <= a_tail + AW'(1);
      if (resp)   a_head <= a_head + AW'(1);
      outstanding <= outstanding + CW'(accept) - CW'(resp);
      if (redirect_valid) begin
        // Everything still in flight belongs to the abandoned path.
        fetch_pc <= {redirect_pc[31:2], 2'b00};
        discard  <= outstanding - CW'(resp);
        q_head   <= '0;
        q_tail   <= '0;
        q_count  <= '0;
      end else begin
        if (accept) fetch_pc <= fetch_pc + 32'd4;
        if (resp && (discard != '0)) discard <= discard - CW'(1);
        if (push) q_tail <= q_tail + AW'(1);
        if (pop)  q_head <= q_head + AW'(1);
        q_count <= q_count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) a_mem[a_tail] <= fetch_pc;
    if (push) begin
      q_instr[q_tail] <= imem_rdata;
      q_pc4[q_tail]   <= resp_addr + 32'd4;
    end
  end

  a_rvalid_tracked: assert property (@(posedge clk) disable iff (!reset)
    imem_rvalid |-> (outstanding != '0));

endmodule
